// File: rtl/ysyx_23060184_wb_arbiter_pkg.sv
// rtl/ysyx_23060184_wb_arbiter_pkg.sv - shared widths, requester indices and round-robin pick helper
package ysyx_23060184_wb_arbiter_pkg;

  localparam int WB_DATA_WIDTH     = 32;
  localparam int WB_REG_ADDR_WIDTH = 5;
  localparam int NUM_GPR           = 32;

  localparam int REQ_WB   = 0;
  localparam int REQ_LATE = 1;

  typedef enum logic {
    PTR_WB   = 1'b0,
    PTR_LATE = 1'b1
  } rr_ptr_e;

  // One-hot grant; on contention the pointer names the requester that wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input rr_ptr_e ptr);
    logic [1:0] gnt;
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (ptr == PTR_LATE) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    return gnt;
  endfunction

endpackage

// File: rtl/ysyx_23060184_rr_arb2.sv
// rtl/ysyx_23060184_rr_arb2.sv - two-way round-robin grant with its pointer register
module ysyx_23060184_rr_arb2
  import ysyx_23060184_wb_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  rr_ptr_e ptr_q;
  rr_ptr_e ptr_d;

  // Grants double as ready, so a grant is always a handshake; none while in reset.
  always_comb begin
    gnt_o = rst_i ? 2'b00 : rr_pick(req_i, ptr_q);
    ptr_d = ptr_q;
    if (gnt_o[REQ_WB]) begin
      ptr_d = PTR_LATE;
    end else if (gnt_o[REQ_LATE]) begin
      ptr_d = PTR_WB;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= PTR_WB;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ysyx_23060184_wb_arbiter.sv
// rtl/ysyx_23060184_wb_arbiter.sv - GPR write-port arbiter, registered write stage and pending-write scoreboard
module ysyx_23060184_wb_arbiter
  import ysyx_23060184_wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = ysyx_23060184_wb_arbiter_pkg::WB_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = ysyx_23060184_wb_arbiter_pkg::WB_REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s0_valid,
  output logic                      s0_ready,
  input  logic [REG_ADDR_WIDTH-1:0] s0_rd,
  input  logic [DATA_WIDTH-1:0]     s0_data,
  input  logic                      s1_valid,
  output logic                      s1_ready,
  input  logic [REG_ADDR_WIDTH-1:0] s1_rd,
  input  logic [DATA_WIDTH-1:0]     s1_data,
  input  logic                      pend_set,
  input  logic [REG_ADDR_WIDTH-1:0] pend_rd,
  input  logic [REG_ADDR_WIDTH-1:0] chk_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] chk_rs2,
  output logic                      hazard,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  output logic                      retire
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       hs0;
  logic       hs1;

  logic [NUM_REGS-1:0]       pend_q;
  logic [NUM_REGS-1:0]       pend_d;
  logic                      we_q;
  logic                      we_d;
  logic [REG_ADDR_WIDTH-1:0] waddr_q;
  logic [REG_ADDR_WIDTH-1:0] waddr_d;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH-1:0]     wdata_d;
  logic                      retire_q;
  logic                      retire_d;
  logic                      staged_hit;

  assign req[REQ_WB]   = s0_valid;
  assign req[REQ_LATE] = s1_valid;

  ysyx_23060184_rr_arb2 u_rr_arb2 (
    .clk_i (clk),
    .rst_i (rst),
    .req_i (req),
    .gnt_o (gnt)
  );

  assign s0_ready = gnt[REQ_WB];
  assign s1_ready = gnt[REQ_LATE];
  assign hs0      = s0_valid & s0_ready;
  assign hs1      = s1_valid & s1_ready;

  // A same-cycle set beats the clear so a freshly issued op is never lost.
  always_comb begin
    pend_d = pend_q;
    if (hs1) begin
      pend_d[s1_rd] = 1'b0;
    end
    if (pend_set) begin
      pend_d[pend_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // Writes to x0 are still accepted and retired but never reach the file.
  always_comb begin
    we_d     = 1'b0;
    retire_d = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    if (hs0) begin
      we_d     = (s0_rd != '0);
      waddr_d  = s0_rd;
      wdata_d  = s0_data;
      retire_d = 1'b1;
    end else if (hs1) begin
      we_d    = (s1_rd != '0);
      waddr_d = s1_rd;
      wdata_d = s1_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      retire_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      retire_q <= retire_d;
    end
  end

  // The staged write lands at the end of this cycle, so decode must not read it yet.
  assign staged_hit = we_q && (waddr_q != '0) && ((waddr_q == chk_rs1) || (waddr_q == chk_rs2));
  assign hazard     = !rst && (pend_q[chk_rs1] || pend_q[chk_rs2] || staged_hit);

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign retire   = retire_q;

endmodule
